// File: rtl/fmul_issue.sv
// fmul_issue: issue/writeback controller for the single-precision multiplier.
// Accepts operand pairs, holds them on mul_x1/mul_x2 across the MUL and CAPT
// cycles, then buffers {tag, mul_y} in a DEPTH-entry FIFO toward writeback.
// Optional feature: define FMUL_ISSUE_FLUSH_EN to add the synchronous flush port.
module fmul_issue #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_x1,
    output logic [31:0]      mul_x2,
    input  logic [31:0]      mul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag
`ifdef FMUL_ISSUE_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, MUL, CAPT} state_t;

    state_t             state;
    logic [TAG_W-1:0]   pend_tag;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        mem_y   [DEPTH];
    logic [TAG_W-1:0]   mem_tag [DEPTH];

    logic               flush_w;
    logic               in_fire;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     occ;

`ifdef FMUL_ISSUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Occupancy seen by the issue side: buffered entries plus the push that a
    // CAPT cycle is about to make. A same-cycle pop is deliberately not credited.
    always_comb begin
        occ = {1'b0, count} + {{CNT_W{1'b0}}, (state == CAPT)};
    end

    assign in_ready  = !flush_w && (state != MUL) && (occ < DEPTH_C);
    assign in_fire   = in_valid && in_ready;
    assign push      = (state == CAPT) && !flush_w;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !flush_w;
    assign out_y     = mem_y[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];

    // Issue FSM: load operands on accept and hold them through MUL and CAPT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mul_x1   <= '0;
            mul_x2   <= '0;
            pend_tag <= '0;
        end else if (flush_w) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        mul_x1   <= in_x1;
                        mul_x2   <= in_x2;
                        pend_tag <= in_tag;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    state <= CAPT;
                end
                CAPT: begin
                    if (in_fire) begin
                        mul_x1   <= in_x1;
                        mul_x2   <= in_x2;
                        pend_tag <= in_tag;
                        state    <= MUL;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result FIFO: circular buffer, push from CAPT, pop on the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_y[i]   <= '0;
                mem_tag[i] <= '0;
            end
        end else if (flush_w) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_y[wr_ptr]   <= mul_y;
                mem_tag[wr_ptr] <= pend_tag;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_issue.sv
// tb_fmul_issue: directed bench for fmul_issue with a 1-cycle product-register
// multiplier model and a scoreboard that predicts handshake and FIFO behaviour.
module tb_fmul_issue;

    localparam int TAG_W = 5;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      mul_x1;
    logic [31:0]      mul_x2;
    logic [31:0]      mul_y;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             flush;

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;
    int n_acc  = 0;
    int acc_cyc [4];
    bit wrap_done;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      y;
        int               rdy;
    } ent_t;
    ent_t mq[$];

    fmul_issue #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_tag    (in_tag),
        .mul_x1    (mul_x1),
        .mul_x2    (mul_x2),
        .mul_y     (mul_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag)
`ifdef FMUL_ISSUE_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 1;

    // Truncating single-precision multiply for normal operands (zero keeps sign).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            return {s, e[7:0], p[46:24]};
        end
        return {s, e[7:0], p[45:23]};
    endfunction

    // Multiplier model: product register captures the held operands each edge.
    logic [31:0] prod;
    always @(posedge clk) prod <= fmul(mul_x1, mul_x2);
    assign mul_y = prod;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Present an op and wait (bounded) for acceptance; returns just after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x1    = a;
        in_x2    = b;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 for tag %0d", t);
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_acc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", mq.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each accepted op becomes visible two edges later, in order.
    initial begin : model
        int cyc;
        int last_acc;
        int occ;
        bit rdy_m;
        bit fire_m;
        bit pop_m;
        bit fl_m;
        ent_t e;
        cyc      = 0;
        last_acc = -10;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                cyc      = 0;
                last_acc = -10;
            end else begin
                occ = 0;
                foreach (mq[i]) if (mq[i].rdy <= cyc) occ++;
                rdy_m = !flush && (cyc != last_acc) &&
                        ((occ + ((cyc == last_acc + 1) ? 1 : 0)) < DEPTH);
                chk("in_ready", 32'(in_ready), 32'(rdy_m));
                chk("out_valid", 32'(out_valid), 32'(occ > 0));
                if (occ > 0) begin
                    chk("out_y", out_y, mq[0].y);
                    chk("out_tag", 32'(out_tag), 32'(mq[0].tag));
                end
                fire_m = in_valid && rdy_m;
                pop_m  = (occ > 0) && out_ready;
                fl_m   = flush;
                e.tag  = in_tag;
                e.y    = fmul(in_x1, in_x2);
                @(posedge clk);
                if (!rst) begin
                    cyc++;
                    if (fl_m) begin
                        mq.delete();
                        last_acc = -10;
                    end else begin
                        if (pop_m) void'(mq.pop_front());
                        if (fire_m) begin
                            e.rdy = cyc + 2;
                            mq.push_back(e);
                            last_acc = cyc;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x1     = '0;
        in_x2     = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        wrap_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_mul_x1", mul_x1, 32'd0);
        rst = 1'b0;

        // Single op: 2.0 * 3.0, tag 3, visible exactly two edges after accept.
        issue(32'h4000_0000, 32'h4040_0000, 5'd3);
        chk("single_mul_x1", mul_x1, 32'h4000_0000);
        @(negedge clk);
        chk("single_lat0_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("single_lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("single_lat2_valid", 32'(out_valid), 32'd1);
        chk("single_y", out_y, 32'h40C0_0000);
        chk("single_tag", 32'(out_tag), 32'd3);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Back-to-back: accepts every second cycle, includes a signed zero.
        issue(32'h3F80_0000, 32'h3FC0_0000, 5'd4);
        acc_cyc[0] = tcyc;
        issue(32'hC040_0000, 32'h4000_0000, 5'd5);
        acc_cyc[1] = tcyc;
        issue(32'h8000_0000, 32'h4000_0000, 5'd6);
        acc_cyc[2] = tcyc;
        issue(32'h4100_0000, 32'h3E80_0000, 5'd7);
        acc_cyc[3] = tcyc;
        for (int i = 0; i < 3; i++)
            chk("b2b_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd2);
        drain();

        // Backpressure: third op stalls until the consumer drains.
        out_ready = 1'b0;
        n_acc     = 0;
        fork
            begin
                issue(32'h3F80_0000, 32'h3F80_0000, 5'd0);
                issue(32'h4000_0000, 32'h4000_0000, 5'd1);
                issue(32'h4040_0000, 32'h4040_0000, 5'd2);
            end
            begin
                repeat (10) @(negedge clk);
                chk("bp_accepts", 32'(n_acc), 32'd2);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_head_tag", 32'(out_tag), 32'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Pointer wrap: 10 ops with random consumer readiness.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    issue({1'b0, 8'(110 + i), 23'(i * 77777)},
                          {i[0], 8'(120 + i), 23'(i * 3333)}, 5'(i + 10));
                wrap_done = 1'b1;
            end
            begin
                while (!wrap_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset during CAPT with one result already buffered.
        out_ready = 1'b0;
        issue(32'h4000_0000, 32'h4000_0000, 5'd21);
        issue(32'h4040_0000, 32'h4000_0000, 5'd22);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_stale", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

`ifdef FMUL_ISSUE_FLUSH_EN
        // Flush during CAPT with one buffered result; next op completes normally.
        out_ready = 1'b0;
        issue(32'h4000_0000, 32'h4000_0000, 5'd25);
        issue(32'h4040_0000, 32'h4040_0000, 5'd26);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        issue(32'h4100_0000, 32'h4000_0000, 5'd27);
        @(negedge clk);
        @(negedge clk);
        chk("post_flush_y", out_y, 32'h4180_0000);
        chk("post_flush_tag", 32'(out_tag), 32'd27);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
